// File: rtl/bp_pkg.sv
// Shared predictor-table definitions: flush engine states and saturating
// counter arithmetic usable for any counter width up to CTR_MAX_W.
package bp_pkg;

    localparam int CTR_MAX_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } flush_state_e;

    // Counters narrower than CTR_MAX_W are zero-extended; w selects the ceiling.
    function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [CTR_MAX_W-1:0] top;
        top = CTR_MAX_W'((9'd1 << w) - 9'd1);
        return (v >= top) ? top : v + 1'b1;
    endfunction

    function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Next value of one saturating counter for a taken/not-taken training event.
module sat_ctr_next
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                up_down,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    logic [CTR_MAX_W-1:0] ctr_wide;
    logic [CTR_MAX_W-1:0] nxt_wide;

    assign ctr_wide = CTR_MAX_W'(ctr);
    assign nxt_wide = up_down ? sat_inc(ctr_wide, CTR_BITS) : sat_dec(ctr_wide);
    assign ctr_nxt  = CTR_BITS'(nxt_wide);

endmodule

// File: rtl/sat_counter_table.sv
// Direction-prediction store: DEPTH saturating counters with a combinational
// read port, a clocked training port and a sequential flush engine.
//
//   state | meaning
//   IDLE  | normal operation, training updates accepted
//   WALK  | flush in progress, writing INIT_VAL to entry[ptr] each unstalled cycle
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int INDEX    = 10,
    parameter int CTR_BITS = 2,
    parameter int INIT_VAL = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [INDEX-1:0]    pred_sel,
    input  logic [INDEX-1:0]    update_sel,
    input  logic                update,
    input  logic                up_down,
    input  logic                flush,
    output logic                pred,
    output logic [CTR_BITS-1:0] pred_ctr,
    output logic                conf,
    output logic                busy
);

    localparam logic [CTR_BITS-1:0] INIT_CTR = CTR_BITS'(INIT_VAL);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [INDEX-1:0]    LAST_IDX = INDEX'(DEPTH - 1);

    logic [CTR_BITS-1:0] tbl [DEPTH];
    flush_state_e        state;
    logic [INDEX-1:0]    ptr;
    logic [CTR_BITS-1:0] upd_ctr;
    logic [CTR_BITS-1:0] upd_nxt;
    logic [CTR_BITS-1:0] rd_ctr;

    assign upd_ctr = tbl[update_sel];
    assign rd_ctr  = tbl[pred_sel];

    sat_ctr_next #(
        .CTR_BITS (CTR_BITS)
    ) u_next (
        .ctr     (upd_ctr),
        .up_down (up_down),
        .ctr_nxt (upd_nxt)
    );

    // A flush request wins over a same-cycle update; updates are never queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= INIT_CTR;
            end
            state <= IDLE;
            ptr   <= '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= WALK;
                        ptr   <= '0;
                    end else if (update) begin
                        tbl[update_sel] <= upd_nxt;
                    end
                end
                WALK: begin
                    tbl[ptr] <= INIT_CTR;
                    ptr      <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // While walking, half-flushed contents are hidden behind the init value.
    assign busy     = (state == WALK);
    assign pred_ctr = busy ? INIT_CTR : rd_ctr;
    assign pred     = pred_ctr[CTR_BITS-1];
    assign conf     = !busy && ((rd_ctr == '0) || (rd_ctr == CTR_MAX));

endmodule

// File: tb/tb_sat_counter_table.sv
// Randomized bench for sat_counter_table against an array-based reference model.
module tb_sat_counter_table;

    localparam int DEPTH = 1024;
    localparam int INDEX = 10;
    localparam int CB    = 2;
    localparam int IV    = 1;
    localparam int MAXV  = (1 << CB) - 1;

    localparam int DEPTH2 = 16;
    localparam int INDEX2 = 4;
    localparam int CB2    = 3;
    localparam int IV2    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic [INDEX-1:0] pred_sel;
    logic [INDEX-1:0] update_sel;
    logic             update;
    logic             up_down;
    logic             flush;
    logic             pred;
    logic [CB-1:0]    pred_ctr;
    logic             conf;
    logic             busy;

    logic              s_stall;
    logic [INDEX2-1:0] s_pred_sel;
    logic [INDEX2-1:0] s_update_sel;
    logic              s_update;
    logic              s_up_down;
    logic              s_flush;
    logic              s_pred;
    logic [CB2-1:0]    s_pred_ctr;
    logic              s_conf;
    logic              s_busy;

    int mdl [DEPTH];
    bit m_busy;
    int m_ptr;

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    sat_counter_table #(
        .DEPTH(DEPTH), .INDEX(INDEX), .CTR_BITS(CB), .INIT_VAL(IV)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .pred_sel(pred_sel),
        .update_sel(update_sel), .update(update), .up_down(up_down), .flush(flush),
        .pred(pred), .pred_ctr(pred_ctr), .conf(conf), .busy(busy)
    );

    sat_counter_table #(
        .DEPTH(DEPTH2), .INDEX(INDEX2), .CTR_BITS(CB2), .INIT_VAL(IV2)
    ) dut_w3 (
        .clk(clk), .reset(reset), .stall(s_stall), .pred_sel(s_pred_sel),
        .update_sel(s_update_sel), .update(s_update), .up_down(s_up_down), .flush(s_flush),
        .pred(s_pred), .pred_ctr(s_pred_ctr), .conf(s_conf), .busy(s_busy)
    );

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = IV;
        m_busy = 0;
        m_ptr  = 0;
    endfunction

    // One rising edge of the table as described behaviourally.
    function automatic void m_edge();
        int v;
        if (stall) return;
        if (m_busy) begin
            mdl[m_ptr] = IV;
            m_ptr++;
            if (m_ptr == DEPTH) m_busy = 0;
        end else if (flush) begin
            m_busy = 1;
            m_ptr  = 0;
        end else if (update) begin
            v = mdl[update_sel];
            if (up_down) mdl[update_sel] = (v < MAXV) ? v + 1 : v;
            else         mdl[update_sel] = (v > 0) ? v - 1 : 0;
        end
    endfunction

    // {pred, conf, busy, pred_ctr} expected for the current pred_sel.
    function automatic logic [CB+2:0] expected_bits();
        int c;
        logic e_conf;
        c      = m_busy ? IV : mdl[pred_sel];
        e_conf = !m_busy && (c == 0 || c == MAXV);
        return {((c >> (CB - 1)) & 1) == 1, e_conf, m_busy, CB'(c)};
    endfunction

    task automatic clk_edge();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic test_reset();
        int idx [3] = '{0, 511, 1023};
        reset = 1'b0;
        stall = 0; update = 0; up_down = 0; flush = 0; pred_sel = '0; update_sel = '0;
        s_stall = 0; s_update = 0; s_up_down = 0; s_flush = 0; s_pred_sel = '0; s_update_sel = '0;
        m_reset();
        #23;
        foreach (idx[k]) begin
            pred_sel = INDEX'(idx[k]);
            #1;
            vectors++;
            if ({pred, conf, busy, pred_ctr} !== expected_bits()) begin
                miscompares++;
                $display("FAIL reset_read idx=%0d got %b want %b", idx[k],
                         {pred, conf, busy, pred_ctr}, expected_bits());
            end
        end
        vectors++;
        if ({s_busy, s_pred_ctr} !== {1'b0, CB2'(IV2)}) begin
            miscompares++;
            $display("FAIL reset_w3 got busy=%b ctr=%0d want busy=0 ctr=%0d", s_busy, s_pred_ctr, IV2);
        end
        @(negedge clk);
        reset = 1'b1;
        #2;
    endtask

    task automatic test_saturate();
        int inc_exp [3] = '{2, 3, 3};
        int dec_exp [5] = '{2, 1, 0, 0, 0};
        pred_sel = 10'd5; update_sel = 10'd5; update = 1; up_down = 1;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            #2;
            vectors++;
            if ({pred, conf, busy, pred_ctr} !== expected_bits() || int'(pred_ctr) != inc_exp[i]) begin
                miscompares++;
                $display("FAIL sat_inc step=%0d got %b want %b (ctr %0d)", i,
                         {pred, conf, busy, pred_ctr}, expected_bits(), inc_exp[i]);
            end
        end
        up_down = 0;
        for (int i = 0; i < 5; i++) begin
            clk_edge();
            #2;
            vectors++;
            if ({pred, conf, busy, pred_ctr} !== expected_bits() || int'(pred_ctr) != dec_exp[i]) begin
                miscompares++;
                $display("FAIL sat_dec step=%0d got %b want %b (ctr %0d)", i,
                         {pred, conf, busy, pred_ctr}, expected_bits(), dec_exp[i]);
            end
        end
        update = 0;
    endtask

    task automatic test_wide_counter();
        int want;
        s_pred_sel = 4'd7; s_update_sel = 4'd7; s_up_down = 1; s_update = 1;
        clk_edge();
        s_update = 0;
        #2;
        want = IV2 + 1;
        vectors++;
        if ({s_pred, s_conf, s_pred_ctr} !== {1'b1, 1'b0, CB2'(want)}) begin
            miscompares++;
            $display("FAIL w3_inc got pred=%b conf=%b ctr=%0d want pred=1 conf=0 ctr=%0d",
                     s_pred, s_conf, s_pred_ctr, want);
        end
        s_stall = 1; s_update = 1;
        clk_edge();
        clk_edge();
        s_stall = 0; s_update = 0;
        #2;
        vectors++;
        if (s_pred_ctr !== CB2'(want)) begin
            miscompares++;
            $display("FAIL w3_stall got ctr=%0d want %0d", s_pred_ctr, want);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall      = ($urandom_range(0, 4) == 0);
            update     = $urandom_range(0, 1);
            up_down    = $urandom_range(0, 1);
            update_sel = INDEX'($urandom_range(0, 7));
            pred_sel   = ($urandom_range(0, 1) == 1) ? update_sel : INDEX'($urandom_range(0, 7));
            flush      = 0;
            #2;
            vectors++;
            if ({pred, conf, busy, pred_ctr} !== expected_bits()) begin
                miscompares++;
                $display("FAIL random n=%0d sel=%0d got %b want %b", n, pred_sel,
                         {pred, conf, busy, pred_ctr}, expected_bits());
            end
            clk_edge();
        end
        stall = 0; update = 0;
    endtask

    task automatic test_flush(input int n_stall, input int stall_at, input int reflush_at);
        int cyc;
        pred_sel = 10'd10; update_sel = 10'd10; up_down = 1; update = 1;
        repeat (3) clk_edge();
        update = 0;
        flush  = 1;
        #2;
        vectors++;
        if ({pred, conf, busy, pred_ctr} !== expected_bits()) begin
            miscompares++;
            $display("FAIL flush_pre got %b want %b", {pred, conf, busy, pred_ctr}, expected_bits());
        end
        clk_edge();
        flush = 0;
        cyc = 0;
        while (cyc < DEPTH + 200) begin
            update     = $urandom_range(0, 1);
            up_down    = $urandom_range(0, 1);
            update_sel = ($urandom_range(0, 1) == 1) ? 10'd10 : INDEX'($urandom);
            pred_sel   = ($urandom_range(0, 1) == 1) ? 10'd10 : INDEX'($urandom);
            stall      = (cyc >= stall_at && cyc < stall_at + n_stall);
            flush      = (cyc == reflush_at);
            #2;
            vectors++;
            if ({pred, conf, busy, pred_ctr} !== expected_bits()) begin
                miscompares++;
                $display("FAIL flush_walk cyc=%0d got %b want %b", cyc,
                         {pred, conf, busy, pred_ctr}, expected_bits());
            end
            if (busy !== 1'b1) break;
            cyc++;
            clk_edge();
        end
        update = 0; stall = 0; flush = 0;
        vectors++;
        if (cyc != DEPTH + n_stall) begin
            miscompares++;
            $display("FAIL flush_len got %0d busy cycles want %0d", cyc, DEPTH + n_stall);
        end
        pred_sel = 10'd10;
        #1;
        vectors++;
        if (pred_ctr !== CB'(IV) || {pred, conf, busy, pred_ctr} !== expected_bits()) begin
            miscompares++;
            $display("FAIL flush_after got ctr=%0d want %0d", pred_ctr, IV);
        end
    endtask

    task automatic test_reset_midwalk();
        for (int i = 500; i < 520; i++) begin
            update_sel = INDEX'(i); update = 1; up_down = 1;
            clk_edge();
            clk_edge();
        end
        update = 0;
        pred_sel = 10'd510;
        #2;
        vectors++;
        if ({pred, conf, busy, pred_ctr} !== expected_bits()) begin
            miscompares++;
            $display("FAIL trained got %b want %b", {pred, conf, busy, pred_ctr}, expected_bits());
        end
        flush = 1;
        clk_edge();
        flush = 0;
        repeat (300) clk_edge();
        reset = 1'b0;
        m_reset();
        #2;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midwalk_busy got %b want 0", busy);
        end
        for (int i = 499; i < 521; i++) begin
            pred_sel = INDEX'(i);
            #0.2;
            vectors++;
            if ({pred, conf, busy, pred_ctr} !== expected_bits()) begin
                miscompares++;
                $display("FAIL reset_midwalk idx=%0d got %b want %b", i,
                         {pred, conf, busy, pred_ctr}, expected_bits());
            end
        end
        @(negedge clk);
        reset = 1'b1;
        update_sel = 10'd500; pred_sel = 10'd500; update = 1; up_down = 1;
        clk_edge();
        update = 0;
        #2;
        vectors++;
        if ({pred, conf, busy, pred_ctr} !== expected_bits()) begin
            miscompares++;
            $display("FAIL post_reset_update got %b want %b", {pred, conf, busy, pred_ctr}, expected_bits());
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_saturate();
        test_wide_counter();
        test_random();
        test_flush(0, -1, -1);
        test_flush(10, 400, 600);
        test_reset_midwalk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
